// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instr/pc holding buffer behind the F output slot.
// Load takes effect next cycle; drain or clear empties it next cycle.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clear_i || drain_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one-outstanding imem request, output slot plus skid for stalls,
// redirects kill an in-flight response. Accept in cycle t is visible in t+1.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  fetch_entry_t slot_q, slot_d, slot_nxt;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;

  logic         resp;
  logic         slot_ld;
  logic         skid_load, skid_drain, skid_valid;
  logic [31:0]  target;
  fetch_entry_t resp_entry, skid_entry;

  assign resp       = (state_q == WAIT) && imem_ready && !PCSrcE;
  assign resp_entry = '{instr: imem_rdata, pc: fpc_q};
  assign target     = {PCTargetE[31:2], 2'b00};

  // Output slot: redirect beats stall, a held slot diverts responses to the skid.
  always_comb begin
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    slot_ld    = 1'b0;
    slot_nxt   = resp_entry;
    valid_d    = valid_q;
    if (PCSrcE) begin
      valid_d = 1'b0;
    end else if (StallF) begin
      if (valid_q) begin
        skid_load = resp;
      end else if (resp) begin
        slot_ld = 1'b1;
        valid_d = 1'b1;
      end
    end else if (skid_valid) begin
      slot_ld    = 1'b1;
      slot_nxt   = skid_entry;
      skid_drain = 1'b1;
      valid_d    = 1'b1;
    end else begin
      slot_ld = resp;
      valid_d = resp;
    end
  end

  assign slot_d = slot_ld ? slot_nxt : slot_q;
  assign pcp4_d = slot_ld ? (slot_nxt.pc + PC_STEP) : pcp4_q;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    unique case (state_q)
      WAIT: begin
        if (PCSrcE) begin
          fpc_d   = target;
          state_d = imem_ready ? WAIT : KILL;
        end else if (resp) begin
          fpc_d   = fpc_q + PC_STEP;
          state_d = skid_load ? IDLE : WAIT;
        end
      end
      KILL: begin
        // A response returning alongside a fresh redirect retires the kill now,
        // so the new target request is not itself discarded.
        if (PCSrcE) begin
          fpc_d   = target;
          state_d = imem_ready ? WAIT : KILL;
        end else if (imem_ready) begin
          state_d = WAIT;
        end
      end
      IDLE: begin
        if (PCSrcE) begin
          fpc_d   = target;
          state_d = WAIT;
        end else if (!StallF) begin
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT;
      fpc_q   <= RESET_PC;
      slot_q  <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      slot_q  <= slot_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  fetch_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (PCSrcE),
    .entry_i (resp_entry),
    .valid_o (skid_valid),
    .entry_o (skid_entry)
  );

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = fpc_q;
  assign instrF    = slot_q.instr;
  assign PCF       = slot_q.pc;
  assign PCPlus4F  = pcp4_q;
  assign ValidF    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a variable-latency memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instrF, PCF, PCPlus4F;
  logic        ValidF;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instrF     (instrF),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .ValidF     (ValidF)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back('{instr: instr_of(pc), pc: pc});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_scn(input string name);
    reset  = 1'b1;
    StallF = 1'b0;
    PCSrcE = 1'b0;
    cyc(2);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Memory: answers the latched request after lat cycles of imem_req.
  initial begin : memory
    logic        active;
    int          cnt;
    logic [31:0] req_addr;
    active   = 1'b0;
    cnt      = 0;
    req_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active     = 1'b0;
        cnt        = 0;
        imem_ready = 1'b0;
      end else begin
        if (imem_ready) active = 1'b0;
        if (active) begin
          cnt++;
        end else if (imem_req) begin
          active   = 1'b1;
          cnt      = 0;
          req_addr = imem_addr;
        end
        imem_ready = active && (cnt >= lat - 1);
      end
      imem_rdata = imem_ready ? instr_of(req_addr) : 32'hDEAD_BEEF;
    end
  end

  // An instruction is consumed whenever F/D is enabled with a valid slot.
  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && ValidF && !StallF) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected: got PCF %h expected none", PCF);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", PCF, e.pc);
          chk("mon_instr", instrF, e.instr);
          chk("mon_pcplus4", PCPlus4F, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    cyc(3);
    chk("rst_validf", 32'(ValidF), 32'd0);
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instrf", instrF, 32'h0);
    chk("rst_pcplus4f", PCPlus4F, 32'h0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_state", 32'(dut.state_q), 32'(WAIT));

    // Zero-wait memory streams one instruction per cycle.
    lat = 1;
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(4 * i));
    reset = 1'b0;
    chk("s1_req_first", 32'(imem_req), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("s1_valid", 32'(ValidF), 32'd1);
    end
    cyc(1);
    end_scn("s1");

    // Three-cycle memory.
    lat = 3;
    push(32'h100);
    push(32'h104);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s2_addr_stable", imem_addr, 32'h100);
      chk("s2_req", 32'(imem_req), 32'd1);
      cyc(1);
    end
    chk("s2_first_valid", 32'(ValidF), 32'd1);
    cyc(1);
    chk("s2_bubble_a", 32'(ValidF), 32'd0);
    cyc(1);
    chk("s2_bubble_b", 32'(ValidF), 32'd0);
    cyc(1);
    chk("s2_second_pc", PCF, 32'h104);
    cyc(1);
    end_scn("s2");

    // Four-cycle stall fills the skid.
    lat = 1;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i));
    reset = 1'b0;
    cyc(2);
    StallF = 1'b1;
    chk("s3_slot_at_stall", PCF, 32'h104);
    cyc(1);
    chk("s3_req_idle", 32'(imem_req), 32'd0);
    chk("s3_slot_held", PCF, 32'h104);
    chk("s3_skid_pc", dut.u_skid.entry_o.pc, 32'h108);
    cyc(1);
    chk("s3_req_idle2", 32'(imem_req), 32'd0);
    cyc(1);
    chk("s3_req_idle3", 32'(imem_req), 32'd0);
    cyc(1);
    StallF = 1'b0;
    chk("s3_release_slot", PCF, 32'h104);
    cyc(1);
    chk("s3_drain_pc", PCF, 32'h108);
    cyc(1);
    chk("s3_next_pc", PCF, 32'h10C);
    cyc(1);
    end_scn("s3");

    // Redirect while 0x10C is outstanding.
    lat = 2;
    push(32'h100);
    push(32'h104);
    push(32'h108);
    push(32'h200);
    reset = 1'b0;
    cyc(6);
    chk("s4_slot_before", PCF, 32'h108);
    PCSrcE = 1'b1;
    PCTargetE = 32'h200;
    cyc(1);
    PCSrcE = 1'b0;
    chk("s4_kill_state", 32'(dut.state_q), 32'(KILL));
    chk("s4_kill_bubble", 32'(ValidF), 32'd0);
    cyc(1);
    chk("s4_target_addr", imem_addr, 32'h200);
    chk("s4_wait_state", 32'(dut.state_q), 32'(WAIT));
    cyc(2);
    chk("s4_target_pc", PCF, 32'h200);
    cyc(1);
    end_scn("s4");

    // Redirect while stalled with the skid full.
    lat = 1;
    push(32'h100);
    push(32'h200);
    push(32'h204);
    reset = 1'b0;
    cyc(2);
    StallF = 1'b1;
    cyc(1);
    chk("s5_skid_full", 32'(dut.u_skid.valid_o), 32'd1);
    PCSrcE = 1'b1;
    PCTargetE = 32'h200;
    cyc(1);
    PCSrcE = 1'b0;
    StallF = 1'b0;
    chk("s5_validf", 32'(ValidF), 32'd0);
    chk("s5_skid_clear", 32'(dut.u_skid.valid_o), 32'd0);
    chk("s5_addr", imem_addr, 32'h200);
    chk("s5_req", 32'(imem_req), 32'd1);
    cyc(1);
    chk("s5_target_pc", PCF, 32'h200);
    cyc(1);
    chk("s5_next_pc", PCF, 32'h204);
    cyc(1);
    end_scn("s5");

    // Reset during KILL.
    lat = 3;
    push(32'h100);
    reset = 1'b0;
    PCSrcE = 1'b1;
    PCTargetE = 32'h300;
    cyc(1);
    PCSrcE = 1'b0;
    chk("s6_in_kill", 32'(dut.state_q), 32'(KILL));
    reset = 1'b1;
    cyc(1);
    chk("s6_state", 32'(dut.state_q), 32'(WAIT));
    chk("s6_addr", imem_addr, 32'h100);
    chk("s6_validf", 32'(ValidF), 32'd0);
    reset = 1'b0;
    cyc(3);
    chk("s6_first_pc", PCF, 32'h100);
    chk("s6_first_valid", 32'(ValidF), 32'd1);
    cyc(1);
    end_scn("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
